// File: rtl/qsys_sdram_sysid_pkg.sv
// Shared types and constants for the Qsys SDRAM sysid checker.
package qsys_sdram_sysid_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RD_ID,
    RD_TS,
    CHECK,
    FAIL
  } state_t;

  localparam logic SYSID_ADDR_ID = 1'b0;
  localparam logic SYSID_ADDR_TS = 1'b1;

  localparam logic [31:0] DEFAULT_ID = 32'd0;
  localparam logic [31:0] DEFAULT_TS = 32'd1464758967;

endpackage

// File: rtl/qsys_sdram_sysid_checker.sv
// Reads the sysid ID and timestamp words over Avalon-MM and compares them
// against the expected build values, with a per-read stall timeout.
module qsys_sdram_sysid_checker
  import qsys_sdram_sysid_pkg::*;
#(
  parameter logic [31:0] EXPECTED_ID = DEFAULT_ID,
  parameter logic [31:0] EXPECTED_TS = DEFAULT_TS,
  parameter int unsigned TIMEOUT     = 16
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  output logic        avm_address,
  output logic        avm_read,
  input  logic        avm_waitrequest,
  input  logic [31:0] avm_readdata,
  output logic        busy,
  output logic        done,
  output logic        id_ok,
  output logic        ts_ok,
  output logic        timeout_err,
  output logic [31:0] id_value,
  output logic [31:0] ts_value
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

  state_t             state;
  logic [CNT_W-1:0]   stall_cnt;
  logic [31:0]        id_buf;
  logic               stall_expired;

  always_comb begin
    stall_expired = avm_waitrequest && (stall_cnt == CNT_W'(TIMEOUT));
  end

  // The ID word is staged in id_buf and only committed to id_value at CHECK,
  // so a timeout on the timestamp read leaves both values from the last run.
  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= IDLE;
      stall_cnt   <= '0;
      id_buf      <= '0;
      avm_read    <= 1'b0;
      avm_address <= SYSID_ADDR_ID;
      busy        <= 1'b0;
      done        <= 1'b0;
      id_ok       <= 1'b0;
      ts_ok       <= 1'b0;
      timeout_err <= 1'b0;
      id_value    <= '0;
      ts_value    <= '0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            state       <= RD_ID;
            busy        <= 1'b1;
            avm_read    <= 1'b1;
            avm_address <= SYSID_ADDR_ID;
            stall_cnt   <= '0;
          end
        end
        RD_ID, RD_TS: begin
          if (!avm_waitrequest) begin
            stall_cnt <= '0;
            if (state == RD_ID) begin
              id_buf      <= avm_readdata;
              state       <= RD_TS;
              avm_address <= SYSID_ADDR_TS;
            end else begin
              state       <= CHECK;
              avm_read    <= 1'b0;
              avm_address <= SYSID_ADDR_ID;
              id_value    <= id_buf;
              ts_value    <= avm_readdata;
              id_ok       <= (id_buf == EXPECTED_ID);
              ts_ok       <= (avm_readdata == EXPECTED_TS);
              timeout_err <= 1'b0;
              done        <= 1'b1;
            end
          end else if (stall_expired) begin
            state       <= FAIL;
            stall_cnt   <= '0;
            avm_read    <= 1'b0;
            avm_address <= SYSID_ADDR_ID;
            timeout_err <= 1'b1;
            id_ok       <= 1'b0;
            ts_ok       <= 1'b0;
            done        <= 1'b1;
          end else begin
            stall_cnt <= stall_cnt + CNT_W'(1);
          end
        end
        CHECK, FAIL: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state    <= IDLE;
          busy     <= 1'b0;
          avm_read <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_qsys_sdram_sysid_checker.sv
// Randomized bench for the sysid checker against a cycle-budget reference model.
module tb_qsys_sdram_sysid_checker;

  localparam int unsigned T   = 16;
  localparam logic [31:0] EID = 32'd0;
  localparam logic [31:0] ETS = 32'd1464758967;

  logic        clock, reset, start;
  logic        avm_address, avm_read, avm_waitrequest;
  logic [31:0] avm_readdata;
  logic        busy, done, id_ok, ts_ok, timeout_err;
  logic [31:0] id_value, ts_value;

  qsys_sdram_sysid_checker #(
    .EXPECTED_ID(EID),
    .EXPECTED_TS(ETS),
    .TIMEOUT    (T)
  ) dut (
    .clock          (clock),
    .reset          (reset),
    .start          (start),
    .avm_address    (avm_address),
    .avm_read       (avm_read),
    .avm_waitrequest(avm_waitrequest),
    .avm_readdata   (avm_readdata),
    .busy           (busy),
    .done           (done),
    .id_ok          (id_ok),
    .ts_ok          (ts_ok),
    .timeout_err    (timeout_err),
    .id_value       (id_value),
    .ts_value       (ts_value)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int total = 0;
  int bad   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  // Slave: stalls each read for a programmed number of cycles, then returns data.
  int unsigned stall_id, stall_ts, wcnt;
  logic [31:0] data_id, data_ts;
  assign avm_waitrequest = avm_read && (wcnt < (avm_address ? stall_ts : stall_id));
  assign avm_readdata    = avm_address ? data_ts : data_id;
  always @(posedge clock) begin
    if (!avm_read || !avm_waitrequest) wcnt <= 0;
    else wcnt <= wcnt + 1;
  end

  // Request must hold steady across stall cycles (the timeout exit excepted).
  logic was_stall = 1'b0;
  logic prev_addr = 1'b0;
  always @(negedge clock) begin
    if (was_stall && !done) begin
      check_eq("addr_hold", 32'(avm_address), 32'(prev_addr));
      check_eq("read_hold", 32'(avm_read), 32'd1);
    end
    was_stall = avm_read && avm_waitrequest && !reset;
    prev_addr = avm_address;
  end

  // Reference model state
  logic [31:0] m_id = '0, m_ts = '0;
  logic        m_idok = 1'b0, m_tsok = 1'b0, m_to = 1'b0;

  // Cycles from start to done: RD_ID begins one cycle after start, a read with
  // s stalls takes s+1 cycles, and a read stalling past T fails at T+1.
  function automatic int unsigned exp_latency(input int unsigned sid, input int unsigned sts,
                                              output bit timed_out);
    int unsigned t;
    timed_out = 1'b0;
    t = 1;
    if (sid > T) begin timed_out = 1'b1; return t + T + 1; end
    t += sid + 1;
    if (sts > T) begin timed_out = 1'b1; return t + T + 1; end
    return t + sts + 1;
  endfunction

  task automatic check_model();
    check_eq("id_ok", 32'(id_ok), 32'(m_idok));
    check_eq("ts_ok", 32'(ts_ok), 32'(m_tsok));
    check_eq("timeout_err", 32'(timeout_err), 32'(m_to));
    check_eq("id_value", id_value, m_id);
    check_eq("ts_value", ts_value, m_ts);
  endtask

  task automatic run_seq(input int unsigned sid, input int unsigned sts,
                         input logic [31:0] did, input logic [31:0] dts, input bit restart);
    int unsigned lat, exp_lat, busy_seen;
    bit          to;
    stall_id = sid; stall_ts = sts; data_id = did; data_ts = dts;
    exp_lat = exp_latency(sid, sts, to);
    @(negedge clock); start = 1'b1;
    @(negedge clock); start = 1'b0; lat = 1;
    while (!done && lat < 100) begin
      start = restart && (lat == 2);
      @(negedge clock);
      lat++;
    end
    start = 1'b0;
    check_eq("latency", lat, exp_lat);
    check_eq("busy_at_done", 32'(busy), 32'd1);
    if (to) begin
      m_to = 1'b1; m_idok = 1'b0; m_tsok = 1'b0;
    end else begin
      m_id = did; m_ts = dts; m_idok = (did == EID); m_tsok = (dts == ETS); m_to = 1'b0;
    end
    check_model();
    // start coinciding with done must be dropped
    start = 1'b1;
    @(negedge clock); start = 1'b0;
    check_eq("done_width", 32'(done), 32'd0);
    busy_seen = 0;
    for (int i = 0; i < 4; i++) begin
      if (busy || done) busy_seen++;
      @(negedge clock);
    end
    check_eq("no_requeue", busy_seen, 0);
    check_model();
  endtask

  initial begin
    int unsigned sid, sts;
    logic [31:0] did, dts;
    int unsigned done_seen;
    reset = 1'b1; start = 1'b0;
    stall_id = 0; stall_ts = 0; data_id = EID; data_ts = ETS;
    repeat (3) @(negedge clock);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_done", 32'(done), 32'd0);
    check_eq("rst_read", 32'(avm_read), 32'd0);
    check_eq("rst_addr", 32'(avm_address), 32'd0);
    check_model();
    reset = 1'b0;
    @(negedge clock);

    run_seq(0, 0, EID, ETS, 1'b0);
    run_seq(0, 0, EID, ETS + 32'd1, 1'b0);
    run_seq(3, 3, EID, ETS, 1'b0);
    run_seq(1000, 0, 32'h1234_5678, 32'h9abc_def0, 1'b0);
    run_seq(16, 16, EID, ETS, 1'b0);
    run_seq(17, 0, EID, ETS, 1'b0);
    run_seq(0, 17, 32'h5, ETS, 1'b0);
    run_seq(0, 0, 32'h7, ETS, 1'b1);

    for (int n = 0; n < 30; n++) begin
      sid = ($urandom_range(0, 5) == 0) ? $urandom_range(14, 19) : $urandom_range(0, 3);
      sts = ($urandom_range(0, 5) == 0) ? $urandom_range(14, 19) : $urandom_range(0, 3);
      did = $urandom_range(0, 1) ? EID : $urandom;
      dts = $urandom_range(0, 1) ? ETS : $urandom;
      run_seq(sid, sts, did, dts, 1'($urandom_range(0, 1)));
    end

    // Reset in the middle of a read sequence aborts it silently.
    stall_id = 0; stall_ts = 0; data_id = EID; data_ts = ETS;
    @(negedge clock); start = 1'b1;
    @(negedge clock); start = 1'b0;
    @(negedge clock);
    check_eq("pre_rst_addr", 32'(avm_address), 32'd1);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    m_id = '0; m_ts = '0; m_idok = 1'b0; m_tsok = 1'b0; m_to = 1'b0;
    check_eq("abort_read", 32'(avm_read), 32'd0);
    check_eq("abort_busy", 32'(busy), 32'd0);
    check_eq("abort_addr", 32'(avm_address), 32'd0);
    check_model();
    done_seen = 0;
    for (int i = 0; i < 5; i++) begin
      if (done) done_seen++;
      @(negedge clock);
    end
    check_eq("abort_no_done", done_seen, 0);

    run_seq(2, 1, EID, ETS, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
